// File: rtl/spi_sts_sync_param.sv
// rtl/spi_sts_sync_param.sv - multi-field status synchronizer with stability filter and change pulses
// Optional sticky/irq logic compiled only when SPI_STS_SYNC_STICKY_EN is defined.
module spi_sts_sync_param #(
   parameter int NUM_FIELDS   = 10,
   parameter int FIELD_WIDTH  = 8,
   parameter int SYNC_DEPTH   = 3,
   parameter int STABLE_COUNT = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] sts_in,
   input  logic [NUM_FIELDS-1:0]             sts_clr,
   output logic [NUM_FIELDS*FIELD_WIDTH-1:0] sts_stable,
   output logic [NUM_FIELDS-1:0]             sts_chg,
   output logic [NUM_FIELDS*FIELD_WIDTH-1:0] sts_sticky,
   output logic                              sts_irq
);

   localparam logic [3:0] SC = 4'(STABLE_COUNT);

   logic [FIELD_WIDTH-1:0] sync_q [NUM_FIELDS][SYNC_DEPTH];
   logic [FIELD_WIDTH-1:0] s_q    [NUM_FIELDS];
   logic [3:0]             cnt    [NUM_FIELDS];

   logic [NUM_FIELDS*FIELD_WIDTH-1:0] stable_nxt;
   logic [NUM_FIELDS-1:0]             load;

   // A field is loaded from s_q once its saturating counter reaches STABLE_COUNT.
   always_comb begin
      stable_nxt = sts_stable;
      load       = '0;
      for (int f = 0; f < NUM_FIELDS; f++) begin
         load[f] = (cnt[f] == SC);
         if (load[f])
            stable_nxt[f*FIELD_WIDTH +: FIELD_WIDTH] = s_q[f];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int f = 0; f < NUM_FIELDS; f++) begin
            for (int d = 0; d < SYNC_DEPTH; d++)
               sync_q[f][d] <= '0;
            s_q[f] <= '0;
            cnt[f] <= '0;
         end
         sts_stable <= '0;
         sts_chg    <= '0;
      end else begin
         for (int f = 0; f < NUM_FIELDS; f++) begin
            sync_q[f][0] <= sts_in[f*FIELD_WIDTH +: FIELD_WIDTH];
            for (int d = 1; d < SYNC_DEPTH; d++)
               sync_q[f][d] <= sync_q[f][d-1];
            s_q[f] <= sync_q[f][SYNC_DEPTH-1];
            if (sync_q[f][SYNC_DEPTH-1] != s_q[f])
               cnt[f] <= '0;
            else if (cnt[f] < SC)
               cnt[f] <= cnt[f] + 4'd1;
            sts_chg[f] <= load[f] &&
                          (s_q[f] != sts_stable[f*FIELD_WIDTH +: FIELD_WIDTH]);
         end
         sts_stable <= stable_nxt;
      end
   end

`ifdef SPI_STS_SYNC_STICKY_EN
   logic [NUM_FIELDS*FIELD_WIDTH-1:0] sticky_nxt;

   // Clear drops old history but bits set by the incoming stable value survive.
   always_comb begin
      sticky_nxt = '0;
      for (int f = 0; f < NUM_FIELDS; f++) begin
         if (sts_clr[f])
            sticky_nxt[f*FIELD_WIDTH +: FIELD_WIDTH] =
               stable_nxt[f*FIELD_WIDTH +: FIELD_WIDTH];
         else
            sticky_nxt[f*FIELD_WIDTH +: FIELD_WIDTH] =
               sts_sticky[f*FIELD_WIDTH +: FIELD_WIDTH] |
               stable_nxt[f*FIELD_WIDTH +: FIELD_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sts_sticky <= '0;
         sts_irq    <= 1'b0;
      end else begin
         sts_sticky <= sticky_nxt;
         sts_irq    <= |sts_sticky;
      end
   end
`else
   logic unused_clr;
   assign unused_clr = ^sts_clr;
   assign sts_sticky = '0;
   assign sts_irq    = 1'b0;
`endif

endmodule
